contador_horizontal: RTL and testbench

//   Horizontal pixel counter for the VGA timing chain (640x480@60, 25 MHz pixel clock).
//   - Counts pixel clocks 0..H_TOTAL-1 across one scan line, then wraps to 0.
//   - Flags the last pixel of each line so the vertical counter advances one line.
//   - Feeds the sync generator and the pixel-address logic.

---
 rtl/contador_horizontal.sv | 60 ++++++
 tb/tb_contador_horizontal.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/contador_horizontal.sv
// Horizontal pixel counter for the VGA timing chain: counts 0..H_TOTAL-1 and flags the last pixel.
// Define HSYNC_GEN_EN to add the hsync / h_activo decode outputs.
module contador_horizontal #(
    parameter int H_TOTAL   = 800,
    parameter int CNT_W     = 10,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96
) (
    input  logic             clock,
    input  logic             reset,
    output logic [CNT_W-1:0] cuenta,
`ifdef HSYNC_GEN_EN
    output logic             hsync,
    output logic             h_activo,
`endif
    output logic             cambio_linea
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Parameter sanity: the line must fit in the counter and the sync pulse must fit in the line.
    if ((H_TOTAL < 2) || (H_TOTAL > (2 ** CNT_W)) ||
        (H_VISIBLE + H_FRONT + H_SYNC > H_TOTAL)) begin : g_bad_params
        $error("contador_horizontal: inconsistent timing parameters");
    end

    logic [CNT_W-1:0] cuenta_q;
    logic [CNT_W-1:0] cuenta_d;

    // Wrap by compare; any out-of-range value also lands on 0 at the next edge.
    always_comb begin
        cuenta_d = cuenta_q + ONE;
        if (cuenta_q >= LAST) begin
            cuenta_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta       = cuenta_q;
    assign cambio_linea = (cuenta_q == LAST);

`ifdef HSYNC_GEN_EN
    localparam logic [CNT_W-1:0] VIS_END = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);

    assign h_activo = (cuenta_q < VIS_END);
    assign hsync    = !((cuenta_q >= HS_BEG) && (cuenta_q < HS_END));
`endif

endmodule

// File: tb/tb_contador_horizontal.sv
// Randomized reset/run bench for contador_horizontal: a default 800-pixel line and a 10-pixel variant.
// Expected counts come from "edges since the last sampled reset, modulo the line length".
`timescale 1ns/1ps
module tb_contador_horizontal;

    localparam int H_TOTAL  = 800;
    localparam int CNT_W    = 10;
    localparam int HS_TOTAL = 10;
    localparam int HS_W     = 4;

    logic             clock;
    logic             reset;
    logic [CNT_W-1:0] cuenta;
    logic             cambio_linea;
    logic [HS_W-1:0]  cuenta_s;
    logic             cambio_linea_s;
`ifdef HSYNC_GEN_EN
    logic             hsync;
    logic             h_activo;
    logic             hsync_s;
    logic             h_activo_s;
`endif

    int checks = 0;
    int errors = 0;

    contador_horizontal #(.H_TOTAL(H_TOTAL), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cuenta       (cuenta),
`ifdef HSYNC_GEN_EN
        .hsync        (hsync),
        .h_activo     (h_activo),
`endif
        .cambio_linea (cambio_linea)
    );

    contador_horizontal #(.H_TOTAL(HS_TOTAL), .CNT_W(HS_W),
                          .H_VISIBLE(6), .H_FRONT(1), .H_SYNC(2)) dut_s (
        .clock        (clock),
        .reset        (reset),
        .cuenta       (cuenta_s),
`ifdef HSYNC_GEN_EN
        .hsync        (hsync_s),
        .h_activo     (h_activo_s),
`endif
        .cambio_linea (cambio_linea_s)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position = edges since the last reset edge, modulo line length.
    logic [CNT_W-1:0] exp_q[$];
    logic [HS_W-1:0]  exp_s_q[$];
    longint cyc      = 0;
    longint last_rst = 0;
    bit     seen_rst = 0;

    always @(posedge clock) begin
        if (reset === 1'b0) begin
            last_rst = cyc;
            seen_rst = 1'b1;
        end
        if (seen_rst) begin
            exp_q.push_back(CNT_W'((cyc - last_rst) % H_TOTAL));
            exp_s_q.push_back(HS_W'((cyc - last_rst) % HS_TOTAL));
        end
        cyc++;
    end

    // Scoreboard, sampled on the falling edge
    always @(negedge clock) begin
        logic [CNT_W-1:0] e;
        logic [HS_W-1:0]  es;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            check("cuenta", 32'(cuenta), 32'(e));
            check("cambio_linea", 32'(cambio_linea), 32'(e == CNT_W'(H_TOTAL - 1)));
            check("cuenta_s", 32'(cuenta_s), 32'(es));
            check("cambio_linea_s", 32'(cambio_linea_s), 32'(es == HS_W'(HS_TOTAL - 1)));
`ifdef HSYNC_GEN_EN
            check("h_activo", 32'(h_activo), 32'(e < 640));
            check("hsync", 32'(hsync), 32'(!(e >= 656 && e < 752)));
            check("h_activo_s", 32'(h_activo_s), 32'(es < 6));
            check("hsync_s", 32'(hsync_s), 32'(!(es >= 7 && es < 9)));
`endif
        end
    end

    // Driver tasks
    task automatic pulse_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int pulses;
        int pulses_s;
        int hs_low;
        int hs_first;
        int waited;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        check("reset_cuenta", 32'(cuenta), 32'd0);
        check("reset_cambio", 32'(cambio_linea), 32'd0);
`ifdef HSYNC_GEN_EN
        check("reset_h_activo", 32'(h_activo), 32'd1);
        check("reset_hsync", 32'(hsync), 32'd1);
`endif

        // Two full lines from release, counting line-end pulses
        pulses = 0;
        pulses_s = 0;
        hs_low = 0;
        hs_first = -1;
        for (int i = 0; i < 1600; i++) begin
            check("seq", 32'(cuenta), 32'(i % H_TOTAL));
            if (cambio_linea) pulses++;
            if (i < 20 && cambio_linea_s) pulses_s++;
`ifdef HSYNC_GEN_EN
            if (i < 800 && !hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
`endif
            run(1);
        end
        check("pulses_1600", 32'(pulses), 32'd2);
        check("pulses_small_20", 32'(pulses_s), 32'd2);
`ifdef HSYNC_GEN_EN
        check("hsync_low_len", 32'(hs_low), 32'd96);
        check("hsync_first", 32'(hs_first), 32'd656);
`endif

        // Reset in mid-line at position 400
        waited = 0;
        while (cuenta != CNT_W'(400) && waited < 1000) begin
            run(1);
            waited++;
        end
        check("wait_400", 32'(waited < 1000), 32'd1);
        pulse_reset(1);
        check("midreset_zero", 32'(cuenta), 32'd0);
        check("midreset_no_pulse", 32'(cambio_linea), 32'd0);
        run(1);
        check("resume_1", 32'(cuenta), 32'd1);
        run(1);
        check("resume_2", 32'(cuenta), 32'd2);

        // Randomized run lengths and reset pulses
        for (int k = 0; k < 20; k++) begin
            run($urandom_range(900, 5));
            pulse_reset($urandom_range(3, 1));
        end
        run(850);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
